rgmii_tx_gen: RTL

- Parametrised transmit-side generator for RGMII. Runs entirely in the `clk` domain.
- Accepts GMII bytes from the MAC and produces registered rising/falling-slot values for the external clock and data ODDRs.
- Generalises fixed 10/100/1000 handling: clock divisors are parameters; duty is exactly 50% via half-cycle slots, including for odd divisors.
- Nibble sequencing for 10/100 is internal; speed changes are glitch-free and take effect only between frames.

---
 rtl/rgmii_pkg.sv | 18 +
 rtl/rgmii_tx_clk_div.sv | 71 +++++++
 rtl/rgmii_tx_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rgmii_pkg.sv
// Shared types and defaults for the RGMII transmit generator.
package rgmii_pkg;

    typedef enum logic [1:0] {
        SPEED_10   = 2'b00,
        SPEED_100  = 2'b01,
        SPEED_1000 = 2'b10
    } speed_e;

    localparam int unsigned DEFAULT_DIV_100 = 5;
    localparam int unsigned DEFAULT_DIV_10  = 50;

    // Both 2'b10 and 2'b11 select gigabit.
    function automatic speed_e speed_decode(input logic [1:0] raw);
        return raw[1] ? SPEED_1000 : speed_e'(raw);
    endfunction

endpackage

// File: rtl/rgmii_tx_clk_div.sv
// Period counter and half-slot TX clock pattern. The clock slot registers are loaded from
// next-state values so they line up with the data registers in the top level.
module rgmii_tx_clk_div
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100 = DEFAULT_DIV_100,
    parameter int unsigned DIV_10  = DEFAULT_DIV_10,
    parameter int unsigned CNT_W   = $clog2(DIV_10)
) (
    input  logic   clk,
    input  logic   rst,
    input  speed_e speed_cur,
    input  speed_e speed_next,
    input  logic   restart,
    output logic   last,
    output logic   last_next,
    output logic   clk_1_next,
    output logic   clk_2_next,
    output logic   clk_1,
    output logic   clk_2
);

    localparam int unsigned HW = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST_10  = CNT_W'(DIV_10 - 1);
    localparam logic [CNT_W-1:0] LAST_100 = CNT_W'(DIV_100 - 1);
    localparam logic [HW-1:0]    HALF_10  = HW'(DIV_10);
    localparam logic [HW-1:0]    HALF_100 = HW'(DIV_100);

    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic is_last(input speed_e s, input logic [CNT_W-1:0] c);
        case (s)
            SPEED_10:  return c == LAST_10;
            SPEED_100: return c == LAST_100;
            default:   return 1'b1;
        endcase
    endfunction

    always_comb begin
        last       = is_last(speed_cur, count_q);
        count_d    = (restart || last) ? '0 : count_q + CNT_W'(1);
        last_next  = is_last(speed_next, count_d);
        clk_1_next = 1'b1;
        clk_2_next = 1'b0;
        // Half-slot h = 2*count (+1 for slot 2); the clock is high once h reaches D.
        case (speed_next)
            SPEED_10: begin
                clk_1_next = {count_d, 1'b0} >= HALF_10;
                clk_2_next = {count_d, 1'b1} >= HALF_10;
            end
            SPEED_100: begin
                clk_1_next = {count_d, 1'b0} >= HALF_100;
                clk_2_next = {count_d, 1'b1} >= HALF_100;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            clk_1   <= 1'b1;
            clk_2   <= 1'b0;
        end else begin
            count_q <= count_d;
            clk_1   <= clk_1_next;
            clk_2   <= clk_2_next;
        end
    end

endmodule

// File: rtl/rgmii_tx_gen.sv
// RGMII transmit generator: GMII bytes in, ODDR slot values out, 10/100/1000 with deferred
// speed changes. Optional statistics counters are enabled with RGMII_TX_STATS_EN.
module rgmii_tx_gen
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100 = DEFAULT_DIV_100,
    parameter int unsigned DIV_10  = DEFAULT_DIV_10,
    parameter int unsigned CNT_W   = $clog2(DIV_10)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  speed,
    input  logic [7:0]  mac_gmii_txd,
    input  logic        mac_gmii_tx_en,
    input  logic        mac_gmii_tx_er,
    output logic        mac_gmii_tx_clk_en,
    output logic [1:0]  speed_active,
    output logic        rgmii_tx_clk_1,
    output logic        rgmii_tx_clk_2,
    output logic [3:0]  rgmii_txd_1,
    output logic [3:0]  rgmii_txd_2,
    output logic        rgmii_tx_ctl_1,
    output logic        rgmii_tx_ctl_2
`ifdef RGMII_TX_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] tx_frame_cnt,
    output logic [31:0] tx_byte_cnt,
    output logic [15:0] tx_err_cnt
`endif
);

    speed_e     speed_q, speed_d, speed_req;
    logic       phase_q, phase_d;
    logic [7:0] hold_txd_q, hold_txd_d;
    logic       hold_en_q, hold_en_d, hold_er_q, hold_er_d;
    logic       clk_en_q, clk_en_d;
    logic [3:0] txd_1_q, txd_1_d, txd_2_q, txd_2_d;
    logic       ctl_1_q, ctl_1_d, ctl_2_q, ctl_2_d;
    logic       last, last_next, clk_1_next, clk_2_next, apply;

    rgmii_tx_clk_div #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10),
        .CNT_W   (CNT_W)
    ) u_clk_div (
        .clk        (clk),
        .rst        (rst),
        .speed_cur  (speed_q),
        .speed_next (speed_d),
        .restart    (apply),
        .last       (last),
        .last_next  (last_next),
        .clk_1_next (clk_1_next),
        .clk_2_next (clk_2_next),
        .clk_1      (rgmii_tx_clk_1),
        .clk_2      (rgmii_tx_clk_2)
    );

    always_comb begin
        speed_req = speed_decode(speed);
        // Only switch between frames, on a period boundary, with the nibble phase at rest.
        apply     = last && !phase_q && !hold_en_q && (speed_req != speed_q);
        speed_d   = apply ? speed_req : speed_q;

        hold_txd_d = hold_txd_q;
        hold_en_d  = hold_en_q;
        hold_er_d  = hold_er_q;
        if (clk_en_q) begin
            hold_txd_d = mac_gmii_txd;
            hold_en_d  = mac_gmii_tx_en;
            hold_er_d  = mac_gmii_tx_er;
        end

        phase_d = phase_q;
        if (apply || speed_q == SPEED_1000) begin
            phase_d = 1'b0;
        end else if (last) begin
            phase_d = !clk_en_q;
        end

        clk_en_d = (speed_d == SPEED_1000) || (last_next && (phase_d || !hold_en_d));

        if (speed_d == SPEED_1000) begin
            txd_1_d = hold_txd_d[3:0];
            txd_2_d = hold_txd_d[7:4];
        end else begin
            txd_1_d = phase_d ? hold_txd_d[7:4] : hold_txd_d[3:0];
            txd_2_d = txd_1_d;
        end
        ctl_1_d = clk_1_next ? hold_en_d : (hold_en_d ^ hold_er_d);
        ctl_2_d = clk_2_next ? hold_en_d : (hold_en_d ^ hold_er_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q    <= SPEED_1000;
            phase_q    <= 1'b0;
            hold_txd_q <= '0;
            hold_en_q  <= 1'b0;
            hold_er_q  <= 1'b0;
            clk_en_q   <= 1'b0;
            txd_1_q    <= '0;
            txd_2_q    <= '0;
            ctl_1_q    <= 1'b0;
            ctl_2_q    <= 1'b0;
        end else begin
            speed_q    <= speed_d;
            phase_q    <= phase_d;
            hold_txd_q <= hold_txd_d;
            hold_en_q  <= hold_en_d;
            hold_er_q  <= hold_er_d;
            clk_en_q   <= clk_en_d;
            txd_1_q    <= txd_1_d;
            txd_2_q    <= txd_2_d;
            ctl_1_q    <= ctl_1_d;
            ctl_2_q    <= ctl_2_d;
        end
    end

    assign mac_gmii_tx_clk_en = clk_en_q;
    assign speed_active       = speed_q;
    assign rgmii_txd_1        = txd_1_q;
    assign rgmii_txd_2        = txd_2_q;
    assign rgmii_tx_ctl_1     = ctl_1_q;
    assign rgmii_tx_ctl_2     = ctl_2_q;

`ifdef RGMII_TX_STATS_EN
    logic [31:0] frame_cnt_q, byte_cnt_q;
    logic [15:0] err_cnt_q;
    logic        err_seen_q, acc_byte, acc_end, acc_err;

    assign acc_byte = clk_en_q && mac_gmii_tx_en;
    assign acc_end  = clk_en_q && hold_en_q && !mac_gmii_tx_en;
    assign acc_err  = acc_byte && mac_gmii_tx_er && !err_seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_seen_q  <= 1'b0;
        end else begin
            if (acc_err) begin
                err_seen_q <= 1'b1;
            end else if (acc_end) begin
                err_seen_q <= 1'b0;
            end
            if (stats_clr) begin
                frame_cnt_q <= '0;
                byte_cnt_q  <= '0;
                err_cnt_q   <= '0;
            end else begin
                if (acc_end && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 32'd1;
                if (acc_byte && byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 32'd1;
                if (acc_err && err_cnt_q != '1)   err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign tx_frame_cnt = frame_cnt_q;
    assign tx_byte_cnt  = byte_cnt_q;
    assign tx_err_cnt   = err_cnt_q;
`endif

endmodule
